// File: rtl/spi_clgen.sv
// rtl/spi_clgen.sv - SPI serial clock generator with rising/falling edge strobes
module spi_clgen #(
    parameter int DIVIDER_LEN = 16
) (
    input  logic                   wb_clk,
    input  logic                   wb_reset,
    input  logic                   go,
    input  logic                   tip,
    input  logic                   last,
    input  logic [DIVIDER_LEN-1:0] divider,
    output logic                   sclk,
    output logic                   cpol_0,
    output logic                   cpol_1
);

    logic [DIVIDER_LEN-1:0] cnt;
    logic                   cnt_zero;
    logic                   half_done;
    logic                   rise_en;
    logic                   fall_en;
    logic                   kick_en;

    assign cnt_zero  = (cnt == '0);
    assign half_done = tip && cnt_zero;

    // A rise is suppressed on the final bit so sclk parks low after its last fall.
    assign rise_en = half_done && !sclk && !last;
    assign fall_en = half_done && sclk;

    // With divider 0, spi_shift needs a launch strobe one cycle after go, before tip rises.
    assign kick_en = (divider == '0) && go && !tip;

    always_ff @(posedge wb_clk or negedge wb_reset) begin
        if (!wb_reset) begin
            cnt <= '0;
        end else if (!tip || cnt_zero) begin
            cnt <= divider;
        end else begin
            cnt <= cnt - DIVIDER_LEN'(1);
        end
    end

    always_ff @(posedge wb_clk or negedge wb_reset) begin
        if (!wb_reset) begin
            sclk   <= 1'b0;
            cpol_0 <= 1'b0;
            cpol_1 <= 1'b0;
        end else begin
            if (rise_en || fall_en) begin
                sclk <= ~sclk;
            end
            cpol_0 <= rise_en || kick_en;
            cpol_1 <= fall_en;
        end
    end

endmodule
